note_judge: RTL and testbench

- Rhythm-game hit judgement stage between the note stream and the score/combo renderer.
- Takes per-lane note times from the chart reader over a valid/ready stream and frame-sampled D/F/J/K key levels plus the song timer `un_time`.
- Once per frame, rates each lane's pending note as perfect, good or miss.
- Drives the score, combo and last-judgement (`precise`) values consumed by the sprite and score/combo drawers.

---
 rtl/note_judge_if.sv | 12 +
 rtl/note_judge.sv | 187 ++++++++++++++++++
 tb/tb_note_judge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_judge_if.sv
// Note stream from the chart reader: one per-lane target time per transfer.
interface note_judge_if #(
   parameter int TIME_W = 16
);
   logic              note_valid;
   logic [1:0]        note_lane;
   logic [TIME_W-1:0] note_time;
   logic              note_ready;

   modport master (output note_valid, note_lane, note_time, input note_ready);
   modport slave  (input note_valid, note_lane, note_time, output note_ready);
endinterface

// File: rtl/note_judge.sv
// Rhythm-game hit judgement: holds one pending note per lane and rates each
// lane once per video frame as perfect, good or miss, driving score and combo.
module note_judge #(
   parameter int TIME_W      = 16,
   parameter int SCORE_W     = 13,
   parameter int COMBO_W     = 4,
   parameter int PERFECT_WIN = 2,
   parameter int GOOD_WIN    = 5,
   parameter int MISS_WIN    = 8,
   parameter int PERFECT_PTS = 3,
   parameter int GOOD_PTS    = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               new_frame,
   input  logic [TIME_W-1:0]  un_time,
   input  logic [3:0]         dfjk,
   note_judge_if.slave        note,
   output logic [SCORE_W-1:0] score,
   output logic [COMBO_W-1:0] combo,
   output logic [1:0]         precise,
   output logic               judge_valid,
   output logic [1:0]         judge_lane,
   output logic               busy
);

   typedef enum logic [2:0] {IDLE, SCAN0, SCAN1, SCAN2, SCAN3} state_t;
   typedef enum logic [1:0] {J_NONE, J_PERFECT, J_GOOD, J_MISS} judge_t;

   state_t state, state_next;

   logic [3:0]             slot_valid;
   logic [3:0][TIME_W-1:0] slot_time;
   logic [3:0]             press;
   logic [3:0]             prev_keys;
   logic                   pend;

   logic                   start;
   logic                   scanning;
   logic [1:0]             lane;
   logic [3:0]             key_edge;
   logic [3:0]             press_lanes;
   logic signed [TIME_W-1:0] delta;
   logic signed [31:0]     dv;
   judge_t                 code;
   logic [SCORE_W:0]       score_sum;
   logic [SCORE_W-1:0]     score_next;
   logic [COMBO_W-1:0]     combo_next;

   // Key bits arrive as D,F,J,K from MSB down; reorder so bit i is lane i.
   always_comb begin
      key_edge    = dfjk & ~prev_keys;
      press_lanes = {key_edge[0], key_edge[1], key_edge[2], key_edge[3]};
   end

   always_comb begin
      note.note_ready = (state == IDLE) && !slot_valid[note.note_lane];
      busy            = (state != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      scanning   = 1'b0;
      lane       = 2'd0;
      case (state)
         IDLE: begin
            if (new_frame || pend) begin
               start      = 1'b1;
               state_next = SCAN0;
            end
         end
         SCAN0: begin
            scanning   = 1'b1;
            lane       = 2'd0;
            state_next = SCAN1;
         end
         SCAN1: begin
            scanning   = 1'b1;
            lane       = 2'd1;
            state_next = SCAN2;
         end
         SCAN2: begin
            scanning   = 1'b1;
            lane       = 2'd2;
            state_next = SCAN3;
         end
         SCAN3: begin
            scanning   = 1'b1;
            lane       = 2'd3;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (clear) begin
         state_next = IDLE;
         start      = 1'b0;
         scanning   = 1'b0;
      end
   end

   // Signed distance from the target time; modular wrap keeps timer rollover correct.
   always_comb begin
      delta = un_time - slot_time[lane];
      dv    = {{(32-TIME_W){delta[TIME_W-1]}}, delta};
      code  = J_NONE;
      if (scanning && slot_valid[lane]) begin
         if (press[lane] && dv >= -PERFECT_WIN && dv <= PERFECT_WIN)
            code = J_PERFECT;
         else if (press[lane] && dv >= -GOOD_WIN && dv <= GOOD_WIN)
            code = J_GOOD;
         else if (press[lane] && dv >= -MISS_WIN && dv <= MISS_WIN)
            code = J_MISS;
         else if (dv > MISS_WIN)
            code = J_MISS;
      end
   end

   always_comb begin
      if (code == J_PERFECT)
         score_sum = {1'b0, score} + (SCORE_W+1)'(PERFECT_PTS);
      else
         score_sum = {1'b0, score} + (SCORE_W+1)'(GOOD_PTS);
      score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      combo_next = (combo == '1) ? combo : combo + COMBO_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_valid  <= '0;
         slot_time   <= '0;
         press       <= '0;
         prev_keys   <= '0;
         pend        <= 1'b0;
         score       <= '0;
         combo       <= '0;
         precise     <= '0;
         judge_valid <= 1'b0;
         judge_lane  <= '0;
      end else begin
         judge_valid <= 1'b0;
         if (clear) begin
            // Held keys must not count as a fresh press after a restart.
            slot_valid <= '0;
            slot_time  <= '0;
            press      <= '0;
            prev_keys  <= dfjk;
            pend       <= 1'b0;
            score      <= '0;
            combo      <= '0;
            precise    <= '0;
            judge_lane <= '0;
         end else begin
            if (note.note_valid && note.note_ready) begin
               slot_valid[note.note_lane] <= 1'b1;
               slot_time[note.note_lane]  <= note.note_time;
            end
            if (start) begin
               press     <= press_lanes;
               prev_keys <= dfjk;
               pend      <= 1'b0;
            end else if (new_frame && state != IDLE) begin
               pend <= 1'b1;
            end
            if (code != J_NONE) begin
               slot_valid[lane] <= 1'b0;
               precise          <= code;
               judge_valid      <= 1'b1;
               judge_lane       <= lane;
               if (code == J_MISS) begin
                  combo <= '0;
               end else begin
                  score <= score_next;
                  combo <= combo_next;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: hand-computed judgements, score and combo.
module tb_note_judge;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        new_frame;
   logic [15:0] un_time;
   logic [3:0]  dfjk;
   logic [12:0] score;
   logic [3:0]  combo;
   logic [1:0]  precise;
   logic        judge_valid;
   logic [1:0]  judge_lane;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [3:0] m;

   note_judge_if #(.TIME_W(16)) nif ();

   note_judge #(
      .TIME_W(16), .SCORE_W(13), .COMBO_W(4),
      .PERFECT_WIN(2), .GOOD_WIN(5), .MISS_WIN(8),
      .PERFECT_PTS(3), .GOOD_PTS(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .new_frame(new_frame),
      .un_time(un_time), .dfjk(dfjk), .note(nif),
      .score(score), .combo(combo), .precise(precise),
      .judge_valid(judge_valid), .judge_lane(judge_lane), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [1:0] lane, input logic [15:0] t);
      nif.note_valid = 1'b1;
      nif.note_lane  = lane;
      nif.note_time  = t;
      #1;
      chk("load_ready", 32'(nif.note_ready), 1);
      tick();
      nif.note_valid = 1'b0;
      #1;
   endtask

   task automatic ready_for(input logic [1:0] lane, input logic exp, input string tag);
      nif.note_lane = lane;
      #1;
      chk(tag, 32'(nif.note_ready), 32'(exp));
   endtask

   // One full pass from IDLE; mask bit i = judgement issued for lane i.
   task automatic frame(output logic [3:0] mask);
      mask = '0;
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         mask[i] = judge_valid;
         if (judge_valid) chk("judge_lane", 32'(judge_lane), 32'(i));
      end
   endtask

   initial begin
      reset_n = 1'b0; clear = 1'b0; new_frame = 1'b0;
      un_time = '0; dfjk = '0;
      nif.note_valid = 1'b0; nif.note_lane = '0; nif.note_time = '0;
      tick(); tick();
      chk("rst_score", 32'(score), 0);
      chk("rst_combo", 32'(combo), 0);
      chk("rst_precise", 32'(precise), 0);
      chk("rst_jv", 32'(judge_valid), 0);
      chk("rst_jl", 32'(judge_lane), 0);
      chk("rst_busy", 32'(busy), 0);
      reset_n = 1'b1;
      tick();

      // perfect hit on lane0
      un_time = 16'd101;
      load(2'd0, 16'd100);
      ready_for(2'd0, 1'b0, "slot0_full");
      dfjk = 4'b1000;
      frame(m);
      chk("perf_mask", 32'(m), 32'b0001);
      chk("perf_precise", 32'(precise), 1);
      chk("perf_score", 32'(score), 3);
      chk("perf_combo", 32'(combo), 1);
      ready_for(2'd0, 1'b1, "slot0_freed");
      dfjk = 4'b0000; frame(m);

      // good / in-window miss / early-ignore on lane2
      un_time = 16'd196;
      load(2'd2, 16'd200);
      dfjk = 4'b0010; frame(m);
      chk("good_mask", 32'(m), 32'b0100);
      chk("good_precise", 32'(precise), 2);
      chk("good_score", 32'(score), 4);
      chk("good_combo", 32'(combo), 2);
      dfjk = 4'b0000; frame(m);
      un_time = 16'd292;
      load(2'd2, 16'd300);
      dfjk = 4'b0010; frame(m);
      chk("miss_mask", 32'(m), 32'b0100);
      chk("miss_precise", 32'(precise), 3);
      chk("miss_score", 32'(score), 4);
      chk("miss_combo", 32'(combo), 0);
      dfjk = 4'b0000; frame(m);
      un_time = 16'd390;
      load(2'd2, 16'd400);
      dfjk = 4'b0010; frame(m);
      chk("early_mask", 32'(m), 0);
      ready_for(2'd2, 1'b0, "early_kept");
      dfjk = 4'b0000; frame(m);
      un_time = 16'd400;
      dfjk = 4'b0010; frame(m);
      chk("late_hit_mask", 32'(m), 32'b0100);
      chk("late_hit_score", 32'(score), 7);
      dfjk = 4'b0000; frame(m);

      // late auto-miss boundary on lane3
      un_time = 16'd58;
      load(2'd3, 16'd50);
      frame(m);
      chk("edge8_mask", 32'(m), 0);
      un_time = 16'd59;
      frame(m);
      chk("auto_mask", 32'(m), 32'b1000);
      chk("auto_precise", 32'(precise), 3);
      chk("auto_combo", 32'(combo), 0);
      chk("auto_score", 32'(score), 7);

      // backpressure and four-lane serialisation
      load(2'd1, 16'd500);
      ready_for(2'd1, 1'b0, "bp_lane1");
      load(2'd0, 16'd500);
      load(2'd2, 16'd500);
      load(2'd3, 16'd500);
      un_time = 16'd500;
      dfjk = 4'b1111;
      new_frame = 1'b1; tick(); new_frame = 1'b0;
      chk("busy_scan", 32'(busy), 1);
      ready_for(2'd0, 1'b0, "bp_scan");
      m = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         m[i] = judge_valid;
         if (judge_valid) chk("ser_lane", 32'(judge_lane), 32'(i));
      end
      chk("ser_mask", 32'(m), 32'b1111);
      chk("ser_score", 32'(score), 19);
      chk("ser_combo", 32'(combo), 4);
      ready_for(2'd1, 1'b1, "bp_freed");
      dfjk = 4'b0000; frame(m);

      // saturation
      for (int r = 0; r < 680; r++) begin
         for (int l = 0; l < 4; l++) load(2'(l), 16'd500);
         dfjk = 4'b1111; frame(m);
         dfjk = 4'b0000; frame(m);
      end
      chk("sat_pre_score", 32'(score), 8179);
      chk("sat_combo", 32'(combo), 15);
      load(2'd0, 16'd496);
      dfjk = 4'b1000; frame(m);
      chk("sat_good_score", 32'(score), 8180);
      dfjk = 4'b0000; frame(m);
      for (int l = 0; l < 4; l++) load(2'(l), 16'd500);
      dfjk = 4'b1111; frame(m);
      chk("sat_cap_score", 32'(score), 8191);
      dfjk = 4'b0000; frame(m);
      for (int l = 0; l < 4; l++) load(2'(l), 16'd500);
      dfjk = 4'b1111; frame(m);
      chk("sat_hold_score", 32'(score), 8191);
      chk("sat_hold_combo", 32'(combo), 15);
      dfjk = 4'b0000; frame(m);

      // clear with a held key
      dfjk = 4'b1000;
      load(2'd0, 16'd500);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clr_score", 32'(score), 0);
      chk("clr_combo", 32'(combo), 0);
      chk("clr_precise", 32'(precise), 0);
      ready_for(2'd0, 1'b1, "clr_slot");
      load(2'd0, 16'd500);
      frame(m);
      chk("clr_noedge", 32'(m), 0);
      ready_for(2'd0, 1'b0, "clr_kept");
      dfjk = 4'b0000; frame(m);

      // timer wrap: 0xFFFE hit at 0x0001 is +3 -> good
      un_time = 16'h0001;
      load(2'd1, 16'hFFFE);
      dfjk = 4'b0100; frame(m);
      chk("wrap_mask", 32'(m), 32'b0010);
      chk("wrap_precise", 32'(precise), 2);
      chk("wrap_score", 32'(score), 1);
      dfjk = 4'b0000; frame(m);

      // new_frame during SCAN1 queues a second pass
      new_frame = 1'b1; tick(); new_frame = 1'b0;
      tick();
      new_frame = 1'b1; tick(); new_frame = 1'b0;
      tick(); tick();
      chk("pend_idle", 32'(busy), 0);
      tick();
      chk("pend_rerun", 32'(busy), 1);
      tick(); tick(); tick(); tick();
      chk("pend_done", 32'(busy), 0);

      // async reset in the middle of SCAN2
      un_time = 16'd500;
      dfjk = 4'b1010;
      new_frame = 1'b1; tick(); new_frame = 1'b0;
      tick();
      chk("pre_rst_score", 32'(score), 4);
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("arst_score", 32'(score), 0);
      chk("arst_combo", 32'(combo), 0);
      chk("arst_precise", 32'(precise), 0);
      chk("arst_busy", 32'(busy), 0);
      tick();
      reset_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
